// File: rtl/mat_pkg.sv
// mat_pkg: shared widths and FSM state encoding for the matrix operand feeder
package mat_pkg;
  localparam int OPW = 8;
  localparam int IW = 6;
  localparam int RW = 22;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_RES, WRITE, FIN} state_e;
endpackage

// File: rtl/mat_index_counter.sv
// mat_index_counter: nested i/j/k element and term counters with wrap flags
module mat_index_counter
  import mat_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 8,
  parameter int P = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_k_i,
  input  logic          inc_ij_i,
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o,
  output logic [IW-1:0] k_o,
  output logic          k_last_o,
  output logic          j_last_o,
  output logic          i_last_o
);
  logic [IW-1:0] i_q, j_q, k_q, i_d, j_d, k_d;
  assign k_last_o = k_q == IW'(N - 1);
  assign j_last_o = j_q == IW'(P - 1);
  assign i_last_o = i_q == IW'(M - 1);
  assign i_o = i_q;
  assign j_o = j_q;
  assign k_o = k_q;
  // k steps per issued pair; j steps per written element and carries into i
  always_comb begin
    k_d = clr_i ? '0 : inc_k_i ? (k_last_o ? '0 : k_q + IW'(1)) : k_q;
    j_d = clr_i ? '0 : inc_ij_i ? (j_last_o ? '0 : j_q + IW'(1)) : j_q;
    i_d = clr_i ? '0 : (inc_ij_i && j_last_o) ? (i_last_o ? '0 : i_q + IW'(1)) : i_q;
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end
endmodule

// File: rtl/mat_operand_feeder.sv
// mat_operand_feeder: sequences A/B operand reads into a MAC and writes back C = A*B
// Optional perf_cycles busy-cycle counter enabled by MAT_FEEDER_PERF_CNT_EN.
module mat_operand_feeder
  import mat_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 8,
  parameter int P = 4,
  parameter int AW = 12,
  parameter int RES_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  output logic           busy,
  output logic           finished,
  output logic [AW-1:0]  a_addr,
  output logic [AW-1:0]  b_addr,
  input  logic [OPW-1:0] a_rdata,
  input  logic [OPW-1:0] b_rdata,
  output logic [OPW-1:0] mac_a,
  output logic [OPW-1:0] mac_b,
  output logic [IW-1:0]  mac_q,
  output logic           mac_start,
  output logic           mac_done,
  input  logic [RW-1:0]  mac_result,
  output logic           res_we,
  output logic [AW-1:0]  res_addr,
  output logic [RW-1:0]  res_wdata
`ifdef MAT_FEEDER_PERF_CNT_EN
  ,
  output logic [15:0]    perf_cycles
`endif
);
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic clr, inc_k, inc_ij, cap, issue;
  logic [IW-1:0] i, j, k;
  logic k_last, j_last, i_last;
  logic [AW-1:0] a_addr_q, b_addr_q, res_addr_q;
  logic [RW-1:0] res_q;
  logic v1_q, l1_q, l2_q;
  logic [IW-1:0] k1_q;
  logic [OPW-1:0] mac_a_q, mac_b_q;
  logic [IW-1:0] mac_q_q;
  logic mac_start_q, mac_done_q;

  mat_index_counter #(.M(M), .N(N), .P(P)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .inc_k_i  (inc_k),
    .inc_ij_i (inc_ij),
    .i_o      (i),
    .j_o      (j),
    .k_o      (k),
    .k_last_o (k_last),
    .j_last_o (j_last),
    .i_last_o (i_last)
  );

  assign issue     = state_q == ISSUE;
  assign busy      = state_q != IDLE && state_q != FIN;
  assign finished  = state_q == FIN;
  assign res_we    = state_q == WRITE;
  assign a_addr    = issue ? AW'(i) * AW'(N) + AW'(k) : a_addr_q;
  assign b_addr    = issue ? AW'(k) * AW'(P) + AW'(j) : b_addr_q;
  assign res_addr  = res_addr_q;
  assign res_wdata = res_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_q     = mac_q_q;
  assign mac_start = mac_start_q;
  assign mac_done  = mac_done_q;

  // next state; cnt_q times DRAIN and WAIT_RES from the cycle the state was entered
  always_comb begin
    state_d = state_q;
    clr = 1'b0;
    inc_k = 1'b0;
    inc_ij = 1'b0;
    cap = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        state_d = ISSUE;
        clr = 1'b1;
      end
      ISSUE: begin
        inc_k = 1'b1;
        if (k_last) state_d = DRAIN;
      end
      DRAIN: if (cnt_q == 3'd1) state_d = WAIT_RES;
      WAIT_RES: if (cnt_q == 3'(RES_LAT - 1)) begin
        state_d = WRITE;
        cap = 1'b1;
      end
      WRITE: begin
        inc_ij = 1'b1;
        state_d = (i_last && j_last) ? FIN : ISSUE;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q) ? cnt_q + 3'd1 : '0;
  end

  // state, address hold, result capture and the two-stage operand pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      res_addr_q  <= '0;
      res_q       <= '0;
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      k1_q        <= '0;
      l2_q        <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_q_q     <= '0;
      mac_start_q <= 1'b0;
      mac_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_addr_q    <= a_addr;
      b_addr_q    <= b_addr;
      if (cap) begin
        res_q      <= mac_result;
        res_addr_q <= AW'(i) * AW'(P) + AW'(j);
      end
      v1_q        <= issue;
      l1_q        <= issue && k_last;
      k1_q        <= k;
      l2_q        <= l1_q;
      mac_a_q     <= v1_q ? a_rdata : '0;
      mac_b_q     <= v1_q ? b_rdata : '0;
      mac_q_q     <= v1_q ? k1_q : '0;
      mac_start_q <= v1_q && k1_q == '0;
      mac_done_q  <= l2_q;
    end
  end

`ifdef MAT_FEEDER_PERF_CNT_EN
  logic [15:0] perf_q;
  assign perf_cycles = perf_q;
  // busy-cycle counter, restarted by an accepted go, saturating at all ones
  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && go)) perf_q <= '0;
    else if (busy && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_mat_operand_feeder.sv
// tb_mat_operand_feeder: directed self-checking bench over four feeder configurations
module tb_mat_operand_feeder;
  logic clk, rst;
  logic go0, go1, go2, go3;
  logic busy0, busy1, busy2, busy3, fin0, fin1, fin2, fin3;
  logic ms0, ms1, ms2, ms3, md0, md1, md2, md3, we0, we1, we2, we3;
  logic [11:0] aa0, aa1, aa2, aa3, ba0, ba1, ba2, ba3, ra0, ra1, ra2, ra3;
  logic [7:0] ar0, ar1, ar2, ar3, br0, br1, br2, br3;
  logic [7:0] ma0, ma1, ma2, ma3, mb0, mb1, mb2, mb3;
  logic [5:0] mq0, mq1, mq2, mq3;
  logic [21:0] mr0, mr1, mr2, mr3, rw0, rw1, rw2, rw3;
`ifdef MAT_FEEDER_PERF_CNT_EN
  logic [15:0] perf0, perf1, perf2, perf3;
`endif

  typedef struct {
    logic [11:0] addr;
    logic [21:0] data;
  } wr_t;
  wr_t exp0[4];

  logic [7:0] am0[4], bm0[4], am1[8], bm1[16];
  logic [11:0] wa0[$];
  logic [21:0] wd0[$];
  int fc0, fc2, wc2;
  logic [11:0] wa2;
  logic [21:0] wd2, wd3;
  int checks, errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mat_operand_feeder #(.M(2), .N(2), .P(2), .AW(12), .RES_LAT(1)) d0 (
    .clk(clk), .rst(rst), .go(go0), .busy(busy0), .finished(fin0),
    .a_addr(aa0), .b_addr(ba0), .a_rdata(ar0), .b_rdata(br0),
    .mac_a(ma0), .mac_b(mb0), .mac_q(mq0), .mac_start(ms0), .mac_done(md0),
    .mac_result(mr0), .res_we(we0), .res_addr(ra0), .res_wdata(rw0)
`ifdef MAT_FEEDER_PERF_CNT_EN
    , .perf_cycles(perf0)
`endif
  );
  mat_operand_feeder #(.M(1), .N(8), .P(2), .AW(12), .RES_LAT(2)) d1 (
    .clk(clk), .rst(rst), .go(go1), .busy(busy1), .finished(fin1),
    .a_addr(aa1), .b_addr(ba1), .a_rdata(ar1), .b_rdata(br1),
    .mac_a(ma1), .mac_b(mb1), .mac_q(mq1), .mac_start(ms1), .mac_done(md1),
    .mac_result(mr1), .res_we(we1), .res_addr(ra1), .res_wdata(rw1)
`ifdef MAT_FEEDER_PERF_CNT_EN
    , .perf_cycles(perf1)
`endif
  );
  mat_operand_feeder #(.M(1), .N(64), .P(1), .AW(12), .RES_LAT(2)) d2 (
    .clk(clk), .rst(rst), .go(go2), .busy(busy2), .finished(fin2),
    .a_addr(aa2), .b_addr(ba2), .a_rdata(ar2), .b_rdata(br2),
    .mac_a(ma2), .mac_b(mb2), .mac_q(mq2), .mac_start(ms2), .mac_done(md2),
    .mac_result(mr2), .res_we(we2), .res_addr(ra2), .res_wdata(rw2)
`ifdef MAT_FEEDER_PERF_CNT_EN
    , .perf_cycles(perf2)
`endif
  );
  mat_operand_feeder #(.M(1), .N(1), .P(1), .AW(12), .RES_LAT(2)) d3 (
    .clk(clk), .rst(rst), .go(go3), .busy(busy3), .finished(fin3),
    .a_addr(aa3), .b_addr(ba3), .a_rdata(ar3), .b_rdata(br3),
    .mac_a(ma3), .mac_b(mb3), .mac_q(mq3), .mac_start(ms3), .mac_done(md3),
    .mac_result(mr3), .res_we(we3), .res_addr(ra3), .res_wdata(rw3)
`ifdef MAT_FEEDER_PERF_CNT_EN
    , .perf_cycles(perf3)
`endif
  );

  // operand memories with one-cycle read latency
  always @(posedge clk) begin
    ar0 <= am0[aa0[1:0]];
    br0 <= bm0[ba0[1:0]];
    ar1 <= am1[aa1[2:0]];
    br1 <= bm1[ba1[3:0]];
  end
  assign ar2 = 8'd255;
  assign br2 = 8'd255;
  assign ar3 = 8'd3;
  assign br3 = 8'd4;

  // MAC models: restart on mac_start, accumulate otherwise (idle pairs are zero)
  always @(posedge clk) begin
    mr0 <= rst ? '0 : ms0 ? 22'(ma0) * 22'(mb0) : mr0 + 22'(ma0) * 22'(mb0);
    mr1 <= rst ? '0 : ms1 ? 22'(ma1) * 22'(mb1) : mr1 + 22'(ma1) * 22'(mb1);
    mr2 <= rst ? '0 : ms2 ? 22'(ma2) * 22'(mb2) : mr2 + 22'(ma2) * 22'(mb2);
    mr3 <= rst ? '0 : ms3 ? 22'(ma3) * 22'(mb3) : mr3 + 22'(ma3) * 22'(mb3);
  end

  // write and finished monitors
  always @(negedge clk) begin
    if (we0) begin
      wa0.push_back(ra0);
      wd0.push_back(rw0);
    end
    if (we2) begin
      wa2 <= ra2;
      wd2 <= rw2;
      wc2 <= wc2 + 1;
    end
    if (we3) wd3 <= rw3;
    fc0 <= fc0 + int'(fin0);
    fc2 <= fc2 + int'(fin2);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    int n, cnt, bc;
    logic [63:0] ga, gd;
    checks = 0;
    errors = 0;
    fc0 = 0;
    fc2 = 0;
    wc2 = 0;
    wa2 = '0;
    wd2 = '0;
    wd3 = '0;
    am0 = '{8'd1, 8'd2, 8'd3, 8'd4};
    bm0 = '{8'd5, 8'd6, 8'd7, 8'd8};
    for (int x = 0; x < 8; x++) am1[x] = 8'(x + 1);
    for (int x = 0; x < 16; x++) bm1[x] = 8'(x + 2);
    exp0[0] = '{12'd0, 22'd19};
    exp0[1] = '{12'd1, 22'd22};
    exp0[2] = '{12'd2, 22'd43};
    exp0[3] = '{12'd3, 22'd50};
    rst = 1'b1;
    go0 = 1'b1;
    go1 = 1'b1;
    go2 = 1'b0;
    go3 = 1'b0;
    repeat (3) @(negedge clk);
    go0 = 1'b0;
    go1 = 1'b0;
    chk("d0_rst_ctl", {busy0, fin0, ms0, md0, we0, ma0, mb0, mq0}, 0);
    chk("d0_rst_addr", {aa0, ba0, ra0, rw0}, 0);
    chk("d1_rst_ctl", {busy1, fin1, ms1, md1, we1, ma1, mb1, mq1}, 0);
    rst = 1'b0;

    // 2x2 product with go held high throughout the run, plus the N=64 element
    @(negedge clk);
    go0 = 1'b1;
    go2 = 1'b1;
    @(negedge clk);
    go2 = 1'b0;
    n = 0;
    while (busy0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    go0 = 1'b0;
    chk("d0_fin_pulse", fin0, 1);
    repeat (20) @(negedge clk);
    chk("d0_fin_count", fc0, 1);
    chk("d0_wr_count", wa0.size(), 4);
    for (int x = 0; x < 4; x++) begin
      ga = 'x;
      gd = 'x;
      if (x < wa0.size()) begin
        ga = 64'(wa0[x]);
        gd = 64'(wd0[x]);
      end
      chk($sformatf("d0_addr%0d", x), ga, 64'(exp0[x].addr));
      chk($sformatf("d0_data%0d", x), gd, 64'(exp0[x].data));
    end
    n = 0;
    while (fc2 == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("d2_fin", fc2, 1);
    chk("d2_wr_count", wc2, 1);
    chk("d2_addr", wa2, 0);
    chk("d2_data", wd2, 4161600);

    // N=8 pair sequence, then reset in the third pair of element (0,1)
    @(negedge clk);
    go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
    n = 0;
    while (!ms1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("d1_start_seen", ms1, 1);
    for (int x = 0; x < 8; x++) begin
      chk($sformatf("d1_pair%0d", x), {ms1, md1, mq1, ma1, mb1},
          {x == 0, 1'b0, 6'(x), 8'(x + 1), 8'(2 * x + 2)});
      @(negedge clk);
    end
    chk("d1_done", {md1, ms1, mq1, ma1, mb1}, {1'b1, 23'd0});
    n = 0;
    while (!we1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("d1_write0", {we1, ra1, rw1}, {1'b1, 12'd0, 22'd408});
    n = 0;
    @(negedge clk);
    while (!ms1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("d1_start2", ms1, 1);
    @(negedge clk);
    @(negedge clk);
    chk("d1_third_pair", {mq1, ma1}, {6'd2, 8'd3});
    rst = 1'b1;
    @(negedge clk);
    chk("d1_abort_ctl", {busy1, fin1, ms1, md1, we1, ma1, mb1, mq1}, 0);
    chk("d1_abort_addr", {aa1, ba1, ra1, rw1}, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(we1) + int'(fin1) + int'(busy1);
    end
    chk("d1_quiet", cnt, 0);

    // single-term run: busy length and optional perf counter
    @(negedge clk);
    go3 = 1'b1;
    @(negedge clk);
    go3 = 1'b0;
    bc = 0;
    n = 0;
    while (!fin3 && n < 50) begin
      if (busy3) bc++;
      @(negedge clk);
      n++;
    end
    chk("d3_fin", {fin3, busy3}, 2'b10);
    chk("d3_busy_cycles", bc, 6);
    chk("d3_data", wd3, 12);
`ifdef MAT_FEEDER_PERF_CNT_EN
    chk("d3_perf", perf3, bc);
    repeat (3) @(negedge clk);
    chk("d3_perf_hold", perf3, bc);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
